// File: rtl/lfsr_gen_pkg.sv
// Shared constants for the LFSR engine: configuration/style names and the
// standard polynomials used by the MAC CRC, PRBS and scrambler users.
package lfsr_gen_pkg;

  localparam string CFG_FIBONACCI   = "FIBONACCI";
  localparam string CFG_GALOIS      = "GALOIS";
  localparam string STYLE_AUTO      = "AUTO";
  localparam string STYLE_LOOP      = "LOOP";
  localparam string STYLE_REDUCTION = "REDUCTION";

  typedef enum logic [1:0] {
    POLY_CRC32,
    POLY_PRBS31,
    POLY_SCRAMBLER58
  } std_poly_e;

  // Polynomials without the x^W term, zero-extended to 64 bits.
  function automatic logic [63:0] std_poly(input std_poly_e sel);
    logic [63:0] poly;
    case (sel)
      POLY_CRC32:       poly = 64'h0000_0000_04C1_1DB7;
      POLY_PRBS31:      poly = 64'h0000_0000_1000_0001;
      POLY_SCRAMBLER58: poly = 64'h0000_0080_0000_0001;
      default:          poly = 64'h0;
    endcase
    return poly;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Multi-step LFSR engine: advances the state DATA_WIDTH bit-steps per
// evaluation using XOR masks derived at elaboration, optionally registered.
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned           LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = LFSR_WIDTH'(std_poly(POLY_PRBS31)),
  parameter string                 LFSR_CONFIG       = CFG_FIBONACCI,
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b0,
  parameter int unsigned           DATA_WIDTH        = 8,
  parameter string                 STYLE             = STYLE_AUTO,
  parameter bit                    REG_OUTPUT        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam int unsigned W    = LFSR_WIDTH;
  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned MW   = W + DW;
  localparam int unsigned NOUT = W + DW;

  localparam bit IS_GALOIS = (LFSR_CONFIG == CFG_GALOIS);
  localparam bit CFG_OK    = IS_GALOIS || (LFSR_CONFIG == CFG_FIBONACCI);
  localparam bit USE_LOOP  = (STYLE == STYLE_LOOP);
  localparam bit STYLE_OK  = (STYLE == STYLE_AUTO) || USE_LOOP || (STYLE == STYLE_REDUCTION);

  typedef logic [MW-1:0]            mask_t;
  typedef logic [NOUT-1:0][MW-1:0]  mask_tbl_t;

  // Rows 0..W-1: internal next-state bits; rows W..W+DW-1: data_out bits.
  // Columns 0..W-1: internal state bits; columns W..W+DW-1: data_in bits.
  function automatic mask_tbl_t lfsr_masks();
    logic [W-1:0][MW-1:0] s;
    mask_tbl_t            tbl;
    mask_t                d;
    mask_t                msb;
    mask_t                fb;
    mask_t                t;
    mask_t                o;
    int unsigned          idx;
    tbl = '0;
    for (int unsigned i = 0; i < W; i++) s[i] = MW'(1) << i;
    for (int unsigned n = 0; n < DW; n++) begin
      idx = REVERSE ? n : (DW - 1 - n);
      d   = MW'(1) << (W + idx);
      msb = s[W-1];
      if (IS_GALOIS) begin
        fb = LFSR_FEED_FORWARD ? d : (msb ^ d);
        o  = LFSR_FEED_FORWARD ? (msb ^ d) : fb;
        for (int unsigned i = W - 1; i > 0; i--) s[i] = s[i-1] ^ (LFSR_POLY[i] ? fb : '0);
        s[0] = LFSR_POLY[0] ? fb : '0;
      end else begin
        t = msb;
        for (int unsigned j = 1; j < W; j++) if (LFSR_POLY[j]) t = t ^ s[j-1];
        o = t ^ d;
        for (int unsigned i = W - 1; i > 0; i--) s[i] = s[i-1];
        s[0] = LFSR_FEED_FORWARD ? d : o;
      end
      tbl[W+idx] = o;
    end
    for (int unsigned i = 0; i < W; i++) tbl[i] = s[i];
    return tbl;
  endfunction

  localparam mask_tbl_t MASKS = lfsr_masks();

  logic [W-1:0]    state_int;
  logic [MW-1:0]   vec;
  logic [NOUT-1:0] res;
  logic [W-1:0]    state_out_d;
  logic [DW-1:0]   data_out_d;

  // REVERSE maps external bit 0 to internal bit W-1 on both sides of the core.
  always_comb begin
    state_int = '0;
    for (int unsigned i = 0; i < W; i++) state_int[i] = REVERSE ? state_in[W-1-i] : state_in[i];
  end

  assign vec = {data_in, state_int};

  if (USE_LOOP) begin : g_loop
    always_comb begin
      res = '0;
      for (int unsigned r = 0; r < NOUT; r++)
        for (int unsigned j = 0; j < MW; j++)
          if (MASKS[r][j]) res[r] = res[r] ^ vec[j];
    end
  end else begin : g_reduction
    for (genvar r = 0; r < NOUT; r++) begin : g_bit
      assign res[r] = ^(MASKS[r] & vec);
    end
  end

  always_comb begin
    state_out_d = '0;
    for (int unsigned i = 0; i < W; i++) state_out_d[i] = REVERSE ? res[W-1-i] : res[i];
    data_out_d = res[NOUT-1:W];
  end

  if (REG_OUTPUT) begin : g_reg
    logic [W-1:0]  state_out_q;
    logic [DW-1:0] data_out_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_out_q <= '0;
        data_out_q  <= '0;
      end else begin
        state_out_q <= state_out_d;
        data_out_q  <= data_out_d;
      end
    end

    assign state_out = state_out_q;
    assign data_out  = data_out_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign state_out      = state_out_d;
    assign data_out       = data_out_d;
  end

  if (!STYLE_OK) begin : g_bad_style
    $error("lfsr_gen: STYLE must be AUTO, LOOP or REDUCTION");
  end
  if (!CFG_OK) begin : g_bad_cfg
    $error("lfsr_gen: LFSR_CONFIG must be FIBONACCI or GALOIS");
  end
  if (W < 2 || DW < 1) begin : g_bad_width
    $error("lfsr_gen: LFSR_WIDTH must be >= 2 and DATA_WIDTH >= 1");
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: CRC-32, PRBS31, multi-step equivalence,
// scrambler round-trip, style equivalence and registered-mode timing.
module tb_lfsr_gen;
  import lfsr_gen_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  string       q_tag[$];
  logic [63:0] q_exp[$];

  task automatic sb_push(input string tag, input logic [63:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    string       tag;
    logic [63:0] exp;
    n_cmp++;
    if (q_exp.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow: observed %h required <none>", obs);
    end else begin
      tag = q_tag.pop_front();
      exp = q_exp.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
    end
  endtask

  function automatic logic [63:0] bitrev(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction

  // Bit-serial reference: one loop iteration per LFSR step.
  task automatic lfsr_model(input bit gal, input bit ff, input bit rev, input int w, input int dw,
                            input logic [63:0] poly, input logic [63:0] st_in, input logic [63:0] dat,
                            output logic [63:0] st_out, output logic [63:0] dout);
    logic [63:0] s, wmask;
    logic        d, msb, t, fb, o;
    int          idx;
    wmask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    s     = rev ? bitrev(st_in, w) : (st_in & wmask);
    dout  = '0;
    for (int n = 0; n < dw; n++) begin
      idx = rev ? n : (dw - 1 - n);
      d   = dat[idx];
      msb = s[w-1];
      if (gal) begin
        fb = ff ? d : (msb ^ d);
        o  = ff ? (msb ^ d) : fb;
        s  = ((s << 1) ^ (fb ? poly : 64'd0)) & wmask;
      end else begin
        t = msb;
        for (int j = 1; j < w; j++) if (poly[j]) t = t ^ s[j-1];
        o = t ^ d;
        s = ((s << 1) | {63'd0, (ff ? d : o)}) & wmask;
      end
      dout[idx] = o;
    end
    st_out = rev ? bitrev(s, w) : s;
  endtask

  localparam logic [63:0] P_CRC = std_poly(POLY_CRC32);

  // CRC-32 (combinational, AUTO style)
  logic [31:0] crc_state_in, crc_state_out;
  logic [7:0]  crc_data_in, crc_data_out;
  lfsr_gen #(.LFSR_WIDTH(32), .LFSR_POLY(32'(P_CRC)), .LFSR_CONFIG(CFG_GALOIS),
             .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b1), .DATA_WIDTH(8),
             .STYLE(STYLE_AUTO), .REG_OUTPUT(1'b0))
    u_crc (.clk(clk), .rst(rst), .data_in(crc_data_in), .state_in(crc_state_in),
           .data_out(crc_data_out), .state_out(crc_state_out));

  // PRBS31 generator, one bit per evaluation
  logic [30:0] prbs_state_in, prbs_state_out;
  logic [0:0]  prbs_data_in, prbs_data_out;
  lfsr_gen #(.LFSR_WIDTH(31), .LFSR_POLY(31'(std_poly(POLY_PRBS31))), .LFSR_CONFIG(CFG_FIBONACCI),
             .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b0), .DATA_WIDTH(1),
             .STYLE(STYLE_AUTO), .REG_OUTPUT(1'b0))
    u_prbs (.clk(clk), .rst(rst), .data_in(prbs_data_in), .state_in(prbs_state_in),
            .data_out(prbs_data_out), .state_out(prbs_state_out));

  // 64b scrambler and self-synchronising descrambler
  logic [57:0] scr_state_in, scr_state_out, dscr_state_in, dscr_state_out;
  logic [63:0] scr_data_in, scr_data_out, dscr_data_in, dscr_data_out;
  lfsr_gen #(.LFSR_WIDTH(58), .LFSR_POLY(58'(std_poly(POLY_SCRAMBLER58))), .LFSR_CONFIG(CFG_FIBONACCI),
             .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b0), .DATA_WIDTH(64),
             .STYLE(STYLE_AUTO), .REG_OUTPUT(1'b0))
    u_scr (.clk(clk), .rst(rst), .data_in(scr_data_in), .state_in(scr_state_in),
           .data_out(scr_data_out), .state_out(scr_state_out));
  lfsr_gen #(.LFSR_WIDTH(58), .LFSR_POLY(58'(std_poly(POLY_SCRAMBLER58))), .LFSR_CONFIG(CFG_FIBONACCI),
             .LFSR_FEED_FORWARD(1'b1), .REVERSE(1'b0), .DATA_WIDTH(64),
             .STYLE(STYLE_AUTO), .REG_OUTPUT(1'b0))
    u_dscr (.clk(clk), .rst(rst), .data_in(dscr_data_in), .state_in(dscr_state_in),
            .data_out(dscr_data_out), .state_out(dscr_state_out));

  // LOOP and REDUCTION builds of the CRC engine
  logic [31:0] sty_state_in, loop_state_out, red_state_out;
  logic [7:0]  sty_data_in, loop_data_out, red_data_out;
  lfsr_gen #(.LFSR_WIDTH(32), .LFSR_POLY(32'(P_CRC)), .LFSR_CONFIG(CFG_GALOIS),
             .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b1), .DATA_WIDTH(8),
             .STYLE(STYLE_LOOP), .REG_OUTPUT(1'b0))
    u_loop (.clk(clk), .rst(rst), .data_in(sty_data_in), .state_in(sty_state_in),
            .data_out(loop_data_out), .state_out(loop_state_out));
  lfsr_gen #(.LFSR_WIDTH(32), .LFSR_POLY(32'(P_CRC)), .LFSR_CONFIG(CFG_GALOIS),
             .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b1), .DATA_WIDTH(8),
             .STYLE(STYLE_REDUCTION), .REG_OUTPUT(1'b0))
    u_red (.clk(clk), .rst(rst), .data_in(sty_data_in), .state_in(sty_state_in),
           .data_out(red_data_out), .state_out(red_state_out));

  // Registered CRC engine
  logic [31:0] reg_state_in, reg_state_out;
  logic [7:0]  reg_data_in, reg_data_out;
  lfsr_gen #(.LFSR_WIDTH(32), .LFSR_POLY(32'(P_CRC)), .LFSR_CONFIG(CFG_GALOIS),
             .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b1), .DATA_WIDTH(8),
             .STYLE(STYLE_AUTO), .REG_OUTPUT(1'b1))
    u_reg (.clk(clk), .rst(rst), .data_in(reg_data_in), .state_in(reg_state_in),
           .data_out(reg_data_out), .state_out(reg_state_out));

  // All CONFIG/FF/REVERSE combinations: g[0]=GALOIS, g[1]=FF, g[2]=REVERSE
  logic [15:0] inv_st [8];
  logic [15:0] inv_sout8 [8];
  logic [15:0] inv_sout1 [8];
  logic [7:0]  inv_dat8 [8];
  logic [7:0]  inv_dout8 [8];
  logic        inv_dat1 [8];
  logic        inv_dout1 [8];
  for (genvar g = 0; g < 8; g++) begin : g_inv
    lfsr_gen #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021),
               .LFSR_CONFIG(((g % 2) == 1) ? CFG_GALOIS : CFG_FIBONACCI),
               .LFSR_FEED_FORWARD(((g / 2) % 2) == 1), .REVERSE(((g / 4) % 2) == 1),
               .DATA_WIDTH(8), .STYLE(STYLE_AUTO), .REG_OUTPUT(1'b0))
      u_dw8 (.clk(clk), .rst(rst), .data_in(inv_dat8[g]), .state_in(inv_st[g]),
             .data_out(inv_dout8[g]), .state_out(inv_sout8[g]));
    lfsr_gen #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021),
               .LFSR_CONFIG(((g % 2) == 1) ? CFG_GALOIS : CFG_FIBONACCI),
               .LFSR_FEED_FORWARD(((g / 2) % 2) == 1), .REVERSE(((g / 4) % 2) == 1),
               .DATA_WIDTH(1), .STYLE(STYLE_AUTO), .REG_OUTPUT(1'b0))
      u_dw1 (.clk(clk), .rst(rst), .data_in(inv_dat1[g]), .state_in(inv_st[g]),
             .data_out(inv_dout1[g]), .state_out(inv_sout1[g]));
  end

  initial begin
    string       msg;
    logic [63:0] st, ns, nd, chain, dout, o1, s1, prev_s, prev_d, sst, dst, word, fcs;
    bit          ph[$];
    bit          gal, ff, rev;
    int          idx;

    msg = "123456789";
    rst = 1'b1;
    crc_state_in = '0;  crc_data_in = '0;
    prbs_state_in = '0; prbs_data_in = '0;
    scr_state_in = '0;  scr_data_in = '0;
    dscr_state_in = '0; dscr_data_in = '0;
    sty_state_in = '0;  sty_data_in = '0;
    reg_state_in = 32'hFFFF_FFFF; reg_data_in = 8'h31;
    for (int g = 0; g < 8; g++) begin
      inv_st[g] = '0; inv_dat8[g] = '0; inv_dat1[g] = 1'b0;
    end

    // Registered mode: reset, 1-cycle latency, hold between edges, mid-stream reset
    @(posedge clk); #1;
    sb_push("reg_rst_state", 64'd0); sb_check(64'(reg_state_out));
    sb_push("reg_rst_data", 64'd0);  sb_check(64'(reg_data_out));
    st = 64'hFFFF_FFFF; prev_s = '0; prev_d = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0;
      reg_state_in = 32'(st);
      reg_data_in  = 8'(msg[i]);
      lfsr_model(1'b1, 1'b0, 1'b1, 32, 8, P_CRC, st, 64'(reg_data_in), ns, nd);
      #1;
      sb_push("reg_hold_state", prev_s); sb_check(64'(reg_state_out));
      sb_push("reg_state", ns); sb_push("reg_data", nd);
      @(posedge clk); #1;
      sb_check(64'(reg_state_out)); sb_check(64'(reg_data_out));
      prev_s = ns; prev_d = nd; st = ns;
    end
    @(negedge clk);
    reg_state_in = 32'(st); reg_data_in = 8'(msg[4]); rst = 1'b1;
    sb_push("reg_midrst_state", 64'd0); sb_push("reg_midrst_data", 64'd0);
    @(posedge clk); #1;
    sb_check(64'(reg_state_out)); sb_check(64'(reg_data_out));
    @(negedge clk);
    rst = 1'b0;
    lfsr_model(1'b1, 1'b0, 1'b1, 32, 8, P_CRC, st, 64'(reg_data_in), ns, nd);
    sb_push("reg_resume_state", ns); sb_push("reg_resume_data", nd);
    @(posedge clk); #1;
    sb_check(64'(reg_state_out)); sb_check(64'(reg_data_out));

    // CRC-32 over "123456789", then the appended FCS leaves the residue
    crc_state_in = '0; crc_data_in = '0; #1;
    sb_push("crc_zero_state", 64'd0); sb_check(64'(crc_state_out));
    sb_push("crc_zero_data", 64'd0);  sb_check(64'(crc_data_out));
    st = 64'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) begin
      crc_state_in = 32'(st); crc_data_in = 8'(msg[i]);
      lfsr_model(1'b1, 1'b0, 1'b1, 32, 8, P_CRC, st, 64'(crc_data_in), ns, nd);
      sb_push("crc_step_state", ns); sb_push("crc_step_data", nd);
      #1;
      sb_check(64'(crc_state_out)); sb_check(64'(crc_data_out));
      st = ns;
    end
    sb_push("crc_check_value", 64'h3407_BC6D9 & 64'h0 | 64'h340B_C6D9); sb_check(64'(crc_state_out));
    fcs = ~st & 64'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      crc_state_in = 32'(st); crc_data_in = 8'(fcs >> (8 * i));
      lfsr_model(1'b1, 1'b0, 1'b1, 32, 8, P_CRC, st, 64'(crc_data_in), ns, nd);
      #1;
      st = 64'(crc_state_out);
    end
    sb_push("crc_residue", 64'hDEBB_20E3); sb_check(64'(crc_state_out));

    // PRBS31 from all-ones: o[n] = o[n-31] ^ o[n-28]
    for (int i = 0; i < 31; i++) ph.push_back(1'b1);
    prbs_data_in = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 31; k++) prbs_state_in[k] = ph[n+30-k];
      ph.push_back(ph[n] ^ ph[n+3]);
      sb_push("prbs_bit", 64'(ph[n+31]));
      for (int k = 0; k < 31; k++) s1[k] = ph[n+31-k];
      sb_push("prbs_state", s1 & 64'h7FFF_FFFF);
      #1;
      sb_check(64'(prbs_data_out)); sb_check(64'(prbs_state_out));
    end

    // Zero property across all combinations
    for (int g = 0; g < 8; g++) begin
      inv_st[g] = '0; inv_dat8[g] = '0;
      sb_push("zero_state", 64'd0); sb_push("zero_data", 64'd0);
    end
    #1;
    for (int g = 0; g < 8; g++) begin
      sb_check(64'(inv_sout8[g])); sb_check(64'(inv_dout8[g]));
    end

    // DW=8 equals eight chained single-bit steps
    for (int r = 0; r < 6; r++) begin
      for (int g = 0; g < 8; g++) begin
        gal = (g % 2) == 1; ff = ((g / 2) % 2) == 1; rev = ((g / 4) % 2) == 1;
        inv_st[g]   = 16'($urandom);
        inv_dat8[g] = 8'($urandom);
        inv_dat1[g] = inv_dat8[g][rev ? 0 : 7];
        chain = 64'(inv_st[g]); dout = '0;
        for (int n = 0; n < 8; n++) begin
          idx = rev ? n : (7 - n);
          lfsr_model(gal, ff, rev, 16, 1, 64'h1021, chain, 64'(inv_dat8[g][idx]), ns, o1);
          if (n == 0) begin
            sb_push("dw1_state", ns); sb_push("dw1_data", o1);
          end
          dout[idx] = o1[0];
          chain = ns;
        end
        sb_push("dw8_state", chain); sb_push("dw8_data", dout);
      end
      #1;
      for (int g = 0; g < 8; g++) begin
        sb_check(64'(inv_sout1[g])); sb_check(64'(inv_dout1[g]));
        sb_check(64'(inv_sout8[g])); sb_check(64'(inv_dout8[g]));
      end
    end

    // LOOP and REDUCTION builds against the reference
    for (int r = 0; r < 300; r++) begin
      sty_state_in = 32'($urandom); sty_data_in = 8'($urandom);
      lfsr_model(1'b1, 1'b0, 1'b1, 32, 8, P_CRC, 64'(sty_state_in), 64'(sty_data_in), ns, nd);
      sb_push("loop_state", ns); sb_push("loop_data", nd);
      sb_push("red_state", ns);  sb_push("red_data", nd);
      #1;
      sb_check(64'(loop_state_out)); sb_check(64'(loop_data_out));
      sb_check(64'(red_state_out));  sb_check(64'(red_data_out));
    end

    // Scrambler -> descrambler with independent seeds
    sst = 64'(58'({$urandom, $urandom}));
    dst = 64'(58'({$urandom, $urandom})) ^ 64'h1;
    for (int wd = 0; wd < 6; wd++) begin
      word = {$urandom, $urandom};
      scr_state_in = 58'(sst); scr_data_in = word;
      #1;
      dscr_state_in = 58'(dst); dscr_data_in = scr_data_out;
      #1;
      if (wd > 0) begin
        sb_push("descrambled", word); sb_check(dscr_data_out);
      end
      sst = 64'(scr_state_out); dst = 64'(dscr_state_out);
    end

    n_cmp++;
    assert (q_exp.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover: observed %0d entries required 0", q_exp.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
